rgb565_frame_buffer: RTL
========================

# rgb565_frame_buffer

Parametrised RGB888-to-RGB565 frame store that sits between the pixel pipeline and the display/readback logic. It converts each accepted 24-bit pixel to 16-bit RGB565, with selectable truncation or rounding, and writes it into an internal frame memory of H_ACTIVE×V_ACTIVE words. It supports start-of-frame resynchronisation and a ready/valid write handshake, and pulses a done flag per completed frame. A registered random-access read port lets downstream logic fetch stored pixels while the next frame is written.

## Interface
- H_ACTIVE, 320, pixels per line
- V_ACTIVE, 408, lines per frame; DEPTH = H_ACTIVE*V_ACTIVE (default 130560)
- ADDR_WIDTH, 17, address width, must satisfy 2^ADDR_WIDTH >= DEPTH
- FCNT_WIDTH, 8, width of completed-frame counter

- iClk  in  1  single clock
- iRst_n  in  1  reset, asynchronous and active-low
- i_Clk_en  in  1  clock enable; all state, memory writes and read registers advance only when high
- i_data_rgb888  in  24  R[23:16], G[15:8], B[7:0]
- i_valid  in  1  input pixel valid
- i_sof  in  1  qualifies pixel as first of frame (sampled only with i_valid)
- i_round  in  1  0 = truncate, 1 = round-half-up with saturation
- o_ready  out  1  write side can accept a pixel
- i_rd_en  in  1  read request
- i_rd_addr  in  ADDR_WIDTH  read address
- o_rd_data  out  16  RGB565 read data
- o_rd_valid  out  1  o_rd_data valid
- o_done_valid  out  1  one-cycle pulse: last pixel of frame written
- o_sof_err  out  1  one-cycle pulse: i_sof arrived mid-frame
- o_frame_cnt  out  FCNT_WIDTH  completed frames, wraps

## Operation
- Accept = i_Clk_en & i_valid & o_ready. Pixels offered while o_ready=0 are dropped, not written; the source must hold them.
- Conversion: truncate gives r5=r8[7:3], g6=g8[7:2], b5=b8[7:3]. Round gives r5=min(31,(r8+4)>>3), g6=min(63,(g8+2)>>2), b5=min(31,(b8+4)>>3). Compute in 9-bit width and saturate; no wrap. Output {r5,g6,b5}.
- Write address: wr_addr. Accepted pixel with i_sof=1 is written at address 0 and sets wr_addr<=1. Otherwise the pixel is written at wr_addr and wr_addr increments.
- FSM, states FILL and DONE:
  - FILL: o_ready=1. Accepting at effective address DEPTH-1 goes to DONE, with wr_addr<=0, o_done_valid<=1, o_frame_cnt+1.
  - DONE: o_ready=0 for exactly one enabled cycle, o_done_valid cleared, then back to FILL.
- i_sof accepted with wr_addr != 0 pulses o_sof_err for one enabled cycle. The partial frame is abandoned: no done pulse, no count increment.
- i_sof=1 when wr_addr == 0 is normal; no error.
- Read port: on enabled cycle with i_rd_en, o_rd_data<=mem[i_rd_addr] and o_rd_valid<=1. Enabled cycle without i_rd_en gives o_rd_valid<=0.
- Out-of-range read (addr >= DEPTH) returns 16'h0000 with o_rd_valid=1.
- Same-address read and write in one cycle returns old data (read-before-write).

## Timing
- Reset values: state=FILL, wr_addr=0, o_ready=1 (combinational from state), o_rd_data=0, o_rd_valid=0, o_done_valid=0, o_sof_err=0, o_frame_cnt=0. Memory contents are not reset.
- Write latency: pixel is visible to a read issued the enabled cycle after acceptance.
- Read latency: 1 enabled cycle.
- o_done_valid asserts in the enabled cycle after the last-pixel accept and lasts one enabled cycle. If i_Clk_en drops, pulses hold until the next enabled edge.
- Throughput: DEPTH pixels per DEPTH+1 enabled cycles, because of the one-cycle DONE gap.
- Reset mid-frame: all counters and pulses clear immediately (asynchronous). The next frame starts at address 0 regardless of i_sof.
- o_frame_cnt wraps from 2^FCNT_WIDTH-1 to 0.

## Test plan
Bench uses H_ACTIVE=4, V_ACTIVE=2 (DEPTH=8).
1. Reset, then 8 accepted pixels with i_round=0, data 24'hF8FCF8 at addr 3 → o_done_valid pulses once the cycle after pixel 8; o_frame_cnt=1; reading addr 3 gives 16'hFFFF one cycle later; o_ready low for one cycle.
2. i_round=1, pixel 24'hFFFFFF → 16'hFFFF (saturated). Pixel 24'h040204 → {5'd1,6'd1,5'd1}=16'h0821. Same pixels with i_round=0 give 16'hFFFF and 16'h0000.
3. 5 pixels, then i_sof=1 pixel 24'h0000F8 → o_sof_err pulse; addr 0 reads 16'h001F; 7 more pixels → o_done_valid fires; o_frame_cnt=1, not 2.
4. i_Clk_en toggling 1/0 each cycle through a full frame → identical memory contents and done pulse. Pulses held across disabled cycles. Pixels presented while i_Clk_en=0 are not written.
5. Read addr 9 → o_rd_data=0, o_rd_valid=1. Simultaneous write and read of addr 2 → old value returned, new value on the next read.
6. Assert iRst_n low mid-frame (after 4 pixels) → all outputs reach reset values asynchronously; the next 8 pixels complete a frame with o_frame_cnt=1. Run 256 frames with FCNT_WIDTH=8 → o_frame_cnt wraps to 0.

Source files
------------

// File: rtl/rgb565_frame_buffer.sv
// rtl/rgb565_frame_buffer.sv - RGB888 to RGB565 frame store with ready/valid write and registered read port
//
// Ports:
//   iClk, iRst_n       clock, asynchronous active-low reset
//   i_Clk_en           clock enable for all state, memory writes and read registers
//   i_data_rgb888      input pixel R[23:16] G[15:8] B[7:0]
//   i_valid, o_ready   write handshake; i_sof marks the first pixel of a frame
//   i_round            0 = truncate, 1 = round-half-up with saturation
//   i_rd_en, i_rd_addr read request; o_rd_data/o_rd_valid one enabled cycle later
//   o_done_valid       pulse after the last pixel of a frame is written
//   o_sof_err          pulse when i_sof is accepted mid-frame
//   o_frame_cnt        completed-frame counter, wraps
module rgb565_frame_buffer #(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 408,
    parameter int ADDR_WIDTH = 17,
    parameter int FCNT_WIDTH = 8
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  i_Clk_en,
    input  logic [23:0]           i_data_rgb888,
    input  logic                  i_valid,
    input  logic                  i_sof,
    input  logic                  i_round,
    output logic                  o_ready,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [15:0]           o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_done_valid,
    output logic                  o_sof_err,
    output logic [FCNT_WIDTH-1:0] o_frame_cnt
);

    localparam int DEPTH = H_ACTIVE * V_ACTIVE;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    // One extra bit so the range check still works when DEPTH == 2^ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt, eff_addr;
    logic                  accept, last_px, sof_mid, rd_in_range;
    logic [8:0]            r_sum, g_sum, b_sum;
    logic [4:0]            r5, b5;
    logic [5:0]            g6;
    logic [15:0]           px565;
    logic [15:0]           mem [DEPTH];

    // Truncation is the same datapath with a zero rounding offset. The 9-bit
    // sum carries out only when rounding would exceed full scale, so the
    // carry selects the saturated value.
    always_comb begin
        r_sum = {1'b0, i_data_rgb888[23:16]} + (i_round ? 9'd4 : 9'd0);
        g_sum = {1'b0, i_data_rgb888[15:8]}  + (i_round ? 9'd2 : 9'd0);
        b_sum = {1'b0, i_data_rgb888[7:0]}   + (i_round ? 9'd4 : 9'd0);
        r5    = r_sum[8] ? 5'd31 : r_sum[7:3];
        g6    = g_sum[8] ? 6'd63 : g_sum[7:2];
        b5    = b_sum[8] ? 5'd31 : b_sum[7:3];
        px565 = {r5, g6, b5};
    end

    assign o_ready     = (state == FILL);
    assign accept      = i_Clk_en & i_valid & o_ready;
    assign eff_addr    = i_sof ? '0 : wr_addr;
    assign last_px     = accept & (eff_addr == LAST_ADDR);
    assign sof_mid     = accept & i_sof & (wr_addr != '0);
    assign rd_in_range = ({1'b0, i_rd_addr} < DEPTH_X);

    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr;
        case (state)
            FILL: begin
                if (accept) begin
                    if (last_px) begin
                        state_nxt   = DONE;
                        wr_addr_nxt = '0;
                    end else begin
                        wr_addr_nxt = eff_addr + 1'b1;
                    end
                end
            end
            DONE: state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state        <= FILL;
            wr_addr      <= '0;
            o_done_valid <= 1'b0;
            o_sof_err    <= 1'b0;
            o_frame_cnt  <= '0;
            o_rd_data    <= 16'h0000;
            o_rd_valid   <= 1'b0;
        end else if (i_Clk_en) begin
            state        <= state_nxt;
            wr_addr      <= wr_addr_nxt;
            o_done_valid <= last_px;
            o_sof_err    <= sof_mid;
            if (last_px) begin
                o_frame_cnt <= o_frame_cnt + 1'b1;
            end
            o_rd_valid <= i_rd_en;
            // Reads sample the array before this edge's write lands, giving
            // read-before-write on an address collision.
            if (i_rd_en) begin
                o_rd_data <= rd_in_range ? mem[i_rd_addr[IDX_W-1:0]] : 16'h0000;
            end
        end
    end

    // Frame memory is not reset.
    always_ff @(posedge iClk) begin
        if (accept) begin
            mem[eff_addr[IDX_W-1:0]] <= px565;
        end
    end

endmodule
